// File: rtl/fp_normalize_if.sv
// Handshake and data bundle for the FP normalizer.
// slave = the normalizer's view; master = the producer/consumer view.
interface fp_normalize_if #(
  parameter int MANTISSA_WIDTH = 24,
  parameter int EXPONENT_WIDTH = 8
);
  logic                      aInValid;
  logic                      anInReady;
  logic                      aInSign;
  logic [EXPONENT_WIDTH-1:0] aInExponent;
  logic [MANTISSA_WIDTH:0]   aInMantissa;
  logic                      aInSticky;
  logic                      anOutValid;
  logic                      aOutReady;
  logic                      anOutSign;
  logic [EXPONENT_WIDTH-1:0] anOutExponent;
  logic [MANTISSA_WIDTH-1:0] anOutMantissa;
  logic                      anOutZero;
  logic                      anOutOverflow;
  logic                      anOutUnderflow;
  logic                      anOutSticky;

  modport slave (
    input  aInValid, aInSign, aInExponent, aInMantissa, aInSticky, aOutReady,
    output anInReady, anOutValid, anOutSign, anOutExponent, anOutMantissa,
           anOutZero, anOutOverflow, anOutUnderflow, anOutSticky
  );

  modport master (
    output aInValid, aInSign, aInExponent, aInMantissa, aInSticky, aOutReady,
    input  anInReady, anOutValid, anOutSign, anOutExponent, anOutMantissa,
           anOutZero, anOutOverflow, anOutUnderflow, anOutSticky
  );
endinterface

// File: rtl/fp_normalize.sv
// Two-stage floating-point normalizer.
// Stage 1 captures the beat and its leading-zero count below the carry bit;
// stage 2 applies the carry/hidden/shift/zero rule and registers the result.
// Both stages use valid/ready with bubble collapsing, so throughput is one
// beat per cycle and a full pipe holds its output while stalled.
module fp_normalize #(
  parameter int MANTISSA_WIDTH = 24,
  parameter int EXPONENT_WIDTH = 8
) (
  input logic           aClock,
  input logic           aReset,
  fp_normalize_if.slave bus
);
  localparam int MW = MANTISSA_WIDTH;
  localparam int EW = EXPONENT_WIDTH;
  localparam int LW = $clog2(MW + 1);
  // Exponent math is one bit wider so increments/decrements never wrap.
  localparam logic [EW:0] ExpOne = (EW+1)'(1);
  localparam logic [EW:0] ExpMax = {1'b0, {EW{1'b1}}};

  logic          s1Valid, s2Valid;
  logic          s1Sign, s1Sticky;
  logic [EW-1:0] s1Exponent;
  logic [MW:0]   s1Mantissa;
  logic [LW-1:0] s1Lzc, inLzc;

  logic          outSign, outZero, outOverflow, outUnderflow, outSticky;
  logic [EW-1:0] outExponent;
  logic [MW-1:0] outMantissa;

  logic          nxtZero, nxtOverflow, nxtUnderflow, nxtSticky;
  logic [EW-1:0] nxtExponent;
  logic [MW-1:0] nxtMantissa;
  logic [EW:0]   expExt, expInc, lzcExt;

  logic s2Advance, inReady;

  assign s2Advance = !s2Valid || bus.aOutReady;
  assign inReady   = !s1Valid || s2Advance;

  // Leading-zero count of the bits below the carry; the highest set bit wins.
  always_comb begin
    inLzc = LW'(MW);
    for (int i = 0; i < MW; i++)
      if (bus.aInMantissa[i]) inLzc = LW'(MW - 1 - i);
  end

  // Stage 1: capture the accepted beat together with its LZC.
  always_ff @(posedge aClock or posedge aReset) begin
    if (aReset) begin
      s1Valid    <= 1'b0;
      s1Sign     <= 1'b0;
      s1Sticky   <= 1'b0;
      s1Exponent <= '0;
      s1Mantissa <= '0;
      s1Lzc      <= '0;
    end else if (inReady) begin
      s1Valid <= bus.aInValid;
      if (bus.aInValid) begin
        s1Sign     <= bus.aInSign;
        s1Sticky   <= bus.aInSticky;
        s1Exponent <= bus.aInExponent;
        s1Mantissa <= bus.aInMantissa;
        s1Lzc      <= inLzc;
      end
    end
  end

  // Normalization rule: zero, carry (with overflow), hidden, shift (with underflow).
  always_comb begin
    nxtExponent  = '0;
    nxtMantissa  = '0;
    nxtZero      = 1'b0;
    nxtOverflow  = 1'b0;
    nxtUnderflow = 1'b0;
    nxtSticky    = 1'b0;
    expExt       = {1'b0, s1Exponent};
    expInc       = expExt + ExpOne;
    lzcExt       = (EW+1)'(s1Lzc);
    if (s1Mantissa == '0) begin
      nxtZero = 1'b1;
    end else if (s1Mantissa[MW]) begin
      // Saturate rather than wrap if the incremented exponent reaches all-ones.
      if (expInc >= ExpMax) begin
        nxtOverflow = 1'b1;
        nxtExponent = '1;
      end else begin
        nxtExponent = expInc[EW-1:0];
        nxtMantissa = s1Mantissa[MW:1];
        nxtSticky   = s1Mantissa[0] | s1Sticky;
      end
    end else if (s1Mantissa[MW-1]) begin
      nxtExponent = s1Exponent;
      nxtMantissa = s1Mantissa[MW-1:0];
      nxtSticky   = s1Sticky;
    end else if (expExt <= lzcExt) begin
      nxtUnderflow = 1'b1;
      nxtZero      = 1'b1;
    end else begin
      nxtExponent = EW'(expExt - lzcExt);
      nxtMantissa = s1Mantissa[MW-1:0] << s1Lzc;
      nxtSticky   = s1Sticky;
    end
  end

  // Stage 2: register the result; hold everything while downstream stalls.
  always_ff @(posedge aClock or posedge aReset) begin
    if (aReset) begin
      s2Valid      <= 1'b0;
      outSign      <= 1'b0;
      outExponent  <= '0;
      outMantissa  <= '0;
      outZero      <= 1'b0;
      outOverflow  <= 1'b0;
      outUnderflow <= 1'b0;
      outSticky    <= 1'b0;
    end else if (s2Advance) begin
      s2Valid <= s1Valid;
      if (s1Valid) begin
        outSign      <= s1Sign;
        outExponent  <= nxtExponent;
        outMantissa  <= nxtMantissa;
        outZero      <= nxtZero;
        outOverflow  <= nxtOverflow;
        outUnderflow <= nxtUnderflow;
        outSticky    <= nxtSticky;
      end
    end
  end

  assign bus.anInReady      = inReady;
  assign bus.anOutValid     = s2Valid;
  assign bus.anOutSign      = outSign;
  assign bus.anOutExponent  = outExponent;
  assign bus.anOutMantissa  = outMantissa;
  assign bus.anOutZero      = outZero;
  assign bus.anOutOverflow  = outOverflow;
  assign bus.anOutUnderflow = outUnderflow;
  assign bus.anOutSticky    = outSticky;
endmodule

// File: tb/tb_fp_normalize.sv
// Bench for fp_normalize: directed vectors with literal expectations plus a
// cycle-by-cycle monitor comparing every valid output against an arithmetic model.
module tb_fp_normalize;
  localparam int MW = 24;
  localparam int EW = 8;

  typedef struct packed {
    logic          sign;
    logic [EW-1:0] exp;
    logic [MW-1:0] mant;
    logic          zero, ovf, unf, sticky;
  } res_t;

  typedef struct packed {
    logic          sign;
    logic [EW-1:0] exp;
    logic [MW:0]   mant;
    logic          sticky;
  } beat_t;

  logic aClock = 1'b0;
  logic aReset = 1'b1;
  fp_normalize_if #(.MANTISSA_WIDTH(MW), .EXPONENT_WIDTH(EW)) bus ();

  fp_normalize #(.MANTISSA_WIDTH(MW), .EXPONENT_WIDTH(EW)) dut (
    .aClock(aClock), .aReset(aReset), .bus(bus)
  );

  always #5 aClock = ~aClock;

  int   tests = 0;
  int   fails = 0;
  int   accepted = 0;
  int   delivered = 0;
  res_t expQ[$];

  // Value-level normalization: scale until the leading one sits at the hidden position.
  function automatic res_t model(beat_t b);
    res_t   r;
    longint m = longint'(b.mant);
    int     e = int'(b.exp);
    int     n = 0;
    r = '0;
    r.sign = b.sign;
    if (m == 0) begin
      r.zero = 1'b1;
    end else if (m >= (longint'(1) << MW)) begin
      if (e + 1 >= (1 << EW) - 1) begin
        r.ovf = 1'b1;
        r.exp = '1;
      end else begin
        r.exp    = EW'(e + 1);
        r.mant   = MW'(m / 2);
        r.sticky = (m % 2 == 1) || b.sticky;
      end
    end else begin
      while (m < (longint'(1) << (MW - 1))) begin
        m = m * 2;
        n++;
      end
      if (e <= n) begin
        r.unf  = 1'b1;
        r.zero = 1'b1;
      end else begin
        r.exp    = EW'(e - n);
        r.mant   = MW'(m);
        r.sticky = b.sticky;
      end
    end
    return r;
  endfunction

  function automatic res_t dutRes();
    return '{bus.anOutSign, bus.anOutExponent, bus.anOutMantissa, bus.anOutZero,
             bus.anOutOverflow, bus.anOutUnderflow, bus.anOutSticky};
  endfunction

  task automatic check(string name, logic [63:0] got, logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Checks each meaningful output cycle and tracks accepted beats.
  task automatic monitor();
    forever begin
      @(negedge aClock);
      if (!aReset) begin
        if (bus.anOutValid) begin
          if (expQ.size() == 0) begin
            check("unexpected_output", 64'(dutRes()), 64'(0));
            tests++; fails++;
            $display("FAIL unexpected_output: valid output with no beat outstanding");
          end else begin
            check("monitor", 64'(dutRes()), 64'(expQ[0]));
            if (bus.aOutReady) begin
              void'(expQ.pop_front());
              delivered++;
            end
          end
        end
        if (bus.aInValid && bus.anInReady) begin
          expQ.push_back(model('{bus.aInSign, bus.aInExponent, bus.aInMantissa, bus.aInSticky}));
          accepted++;
        end
      end
    end
  endtask

  task automatic drive(beat_t b, logic v);
    bus.aInValid    = v;
    bus.aInSign     = b.sign;
    bus.aInExponent = b.exp;
    bus.aInMantissa = b.mant;
    bus.aInSticky   = b.sticky;
  endtask

  // Single beat into an empty pipe; output must appear exactly two edges later.
  task automatic runVec(string name, beat_t b, res_t want);
    bus.aOutReady = 1'b1;
    drive(b, 1'b1);
    @(posedge aClock); #1;
    drive('0, 1'b0);
    check({name, "_early"}, 64'(bus.anOutValid), 64'(0));
    @(posedge aClock); #1;
    check({name, "_valid"}, 64'(bus.anOutValid), 64'(1));
    check(name, 64'(dutRes()), 64'(want));
  endtask

  // Back-to-back stream; downstream stalls for stallCycles from the first output.
  task automatic stream(beat_t beats[$], int stallCycles);
    int idx = 0, firstOut = -1, startDel = delivered;
    bit acc = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge aClock); #1;
      if (acc) idx++;
      if (bus.anOutValid && firstOut < 0) firstOut = cyc;
      bus.aOutReady = !(firstOut >= 0 && cyc - firstOut < stallCycles);
      if (idx < beats.size()) drive(beats[idx], 1'b1);
      else drive('0, 1'b0);
      @(negedge aClock);
      acc = bus.aInValid && bus.anInReady;
      if (stallCycles > 0 && firstOut >= 0 && cyc - firstOut < stallCycles)
        check("stall_inready", 64'(bus.anInReady), 64'(0));
    end
    bus.aOutReady = 1'b1;
    check("stream_delivered", 64'(delivered - startDel), 64'(beats.size()));
    check("stream_drained", 64'(expQ.size()), 64'(0));
  endtask

  initial begin
    beat_t bp[$];
    beat_t mix[$];
    drive('0, 1'b0);
    bus.aOutReady = 1'b1;
    fork monitor(); join_none

    // Reset state.
    repeat (2) @(posedge aClock);
    #1;
    check("reset_outvalid", 64'(bus.anOutValid), 64'(0));
    check("reset_inready", 64'(bus.anInReady), 64'(1));
    check("reset_outputs", 64'(dutRes()), 64'(0));
    aReset = 1'b0;

    // Directed vectors, expectations worked out by hand.
    runVec("hidden",    '{1'b0, 8'd100, 25'h0800000, 1'b0}, '{1'b0, 8'd100, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0});
    runVec("carry",     '{1'b1, 8'd100, 25'h1800001, 1'b0}, '{1'b1, 8'd101, 24'hC00000, 1'b0, 1'b0, 1'b0, 1'b1});
    runVec("overflow",  '{1'b0, 8'd254, 25'h1800001, 1'b0}, '{1'b0, 8'd255, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0});
    runVec("shift",     '{1'b0, 8'd100, 25'h0000100, 1'b1}, '{1'b0, 8'd85,  24'h800000, 1'b0, 1'b0, 1'b0, 1'b1});
    runVec("underflow", '{1'b1, 8'd10,  25'h0000001, 1'b1}, '{1'b1, 8'd0,   24'h000000, 1'b1, 1'b0, 1'b1, 1'b0});
    runVec("shift_min", '{1'b0, 8'd16,  25'h0000100, 1'b0}, '{1'b0, 8'd1,   24'h800000, 1'b0, 1'b0, 1'b0, 1'b0});
    runVec("unf_edge",  '{1'b0, 8'd15,  25'h0000100, 1'b0}, '{1'b0, 8'd0,   24'h000000, 1'b1, 1'b0, 1'b1, 1'b0});
    runVec("zero",      '{1'b0, 8'd77,  25'h0000000, 1'b1}, '{1'b0, 8'd0,   24'h000000, 1'b1, 1'b0, 1'b0, 1'b0});
    runVec("carry_st",  '{1'b0, 8'd1,   25'h1000000, 1'b1}, '{1'b0, 8'd2,   24'h800000, 1'b0, 1'b0, 1'b0, 1'b1});
    @(posedge aClock); #1;

    // Backpressure: 4 beats, 3 stalled cycles at the first output.
    bp = '{'{1'b0, 8'd100, 25'h0800000, 1'b0}, '{1'b1, 8'd50, 25'h1000003, 1'b0},
           '{1'b0, 8'd30,  25'h0000400, 1'b1}, '{1'b1, 8'd9,  25'h0000000, 1'b1}};
    stream(bp, 3);

    // Unstalled mixed stream, checked only by the model.
    mix = '{'{1'b0, 8'd200, 25'h0400000, 1'b0}, '{1'b1, 8'd3,   25'h0200000, 1'b0},
            '{1'b0, 8'd2,   25'h0200000, 1'b1}, '{1'b0, 8'd253, 25'h1FFFFFF, 1'b0},
            '{1'b1, 8'd254, 25'h1000000, 1'b1}, '{1'b0, 8'd128, 25'h0ABCDEF, 1'b1},
            '{1'b1, 8'd24,  25'h0000001, 1'b0}, '{1'b0, 8'd255, 25'h0FFFFFF, 1'b1}};
    stream(mix, 0);

    // Asynchronous reset with two beats in flight.
    drive('{1'b0, 8'd40, 25'h0900000, 1'b0}, 1'b1);
    @(posedge aClock); #1;
    drive('{1'b1, 8'd41, 25'h0A00000, 1'b0}, 1'b1);
    @(posedge aClock); #1;
    drive('0, 1'b0);
    #2;
    aReset = 1'b1;
    expQ.delete();
    #1;
    check("rst_outvalid", 64'(bus.anOutValid), 64'(0));
    check("rst_inready", 64'(bus.anInReady), 64'(1));
    check("rst_outputs", 64'(dutRes()), 64'(0));
    #1;
    aReset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge aClock); #1;
      check("rst_no_stale", 64'(bus.anOutValid), 64'(0));
    end
    runVec("post_reset", '{1'b1, 8'd60, 25'h0000002, 1'b0}, '{1'b1, 8'd38, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0});
    repeat (3) @(posedge aClock);
    #1;
    check("final_drained", 64'(expQ.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fp_normalize.md
FP_NORMALIZE -- requirements
Module: fp_normalize

Interface
REQ-001 Parameter MANTISSA_WIDTH, default 24, mantissa width including hidden bit.
REQ-002 Parameter EXPONENT_WIDTH, default 8, biased unsigned exponent width.
REQ-003 aClock  input  1  single clock; all state updates on rising edge.
REQ-004 aReset  input  1  asynchronous, active-high reset.
REQ-005 aInValid  input  1  input beat valid.
REQ-006 anInReady  output  1  block accepts input this cycle.
REQ-007 aInSign  input  1  sign, passed through unchanged.
REQ-008 aInExponent  input  EXPONENT_WIDTH  biased exponent before normalization.
REQ-009 aInMantissa  input  MANTISSA_WIDTH+1  unnormalized mantissa; MSB = carry, bit MANTISSA_WIDTH-1 = hidden-bit position.
REQ-010 aInSticky  input  1  sticky bit from upstream rounding.
REQ-011 anOutValid  output  1  output beat valid.
REQ-012 aOutReady  input  1  downstream accepts output.
REQ-013 anOutSign / anOutExponent / anOutMantissa  output  1 / EXPONENT_WIDTH / MANTISSA_WIDTH  normalized result.
REQ-014 anOutZero, anOutOverflow, anOutUnderflow, anOutSticky  output  1 each  status flags.

Function
REQ-015 Two-stage pipeline: stage 1 registers inputs plus leading-zero count (LZC) of bits [MANTISSA_WIDTH-1:0]; stage 2 registers shifted result and flags.
REQ-016 Latency is exactly 2 cycles from accepted input to anOutValid with no backpressure; throughput is 1 beat/cycle.
REQ-017 Input transfer occurs when aInValid & anInReady; output transfer when anOutValid & aOutReady.
REQ-018 Each stage advances when it is empty or the stage after it advances; anInReady = stage 1 empty or stage 1 advancing (combinational from aOutReady).
REQ-019 While anOutValid=1 and aOutReady=0, all outputs hold stable.
REQ-020 Case carry (MSB=1): mantissa shifted right 1; exponent+1; anOutSticky = dropped LSB OR aInSticky.
REQ-021 Case hidden (carry=0, hidden bit=1): mantissa and exponent pass unchanged; anOutSticky = aInSticky.
REQ-022 Case shift (carry=0, hidden=0, nonzero): mantissa shifted left by LZC, zero-filled; exponent - LZC; anOutSticky = aInSticky.
REQ-023 Case zero (all mantissa bits 0): exponent 0, mantissa 0, anOutZero=1, no other flag set.
REQ-024 Underflow: case shift with aInExponent <= LZC -> exponent 0, mantissa 0, anOutUnderflow=1, anOutZero=1.
REQ-025 Overflow: case carry with aInExponent+1 == all-ones -> exponent all-ones, mantissa 0, anOutOverflow=1.
REQ-026 Flags are mutually exclusive except anOutZero with anOutUnderflow; anOutSticky is 0 in zero, underflow, overflow cases.
REQ-027 Exponent arithmetic uses EXPONENT_WIDTH+1 bits internally; no wrap-around reaches outputs.

Reset
REQ-028 Asserting aReset clears both stage-valid bits immediately, regardless of clock or in-flight beats.
REQ-029 During and after reset: anOutValid=0, anInReady=1, all data and flag outputs 0.
REQ-030 Beats in flight at reset are discarded; first accepted beat after deassertion appears after exactly 2 cycles.

Verification
REQ-031 Hidden: mantissa 0x0800000, exp 100, aOutReady=1 -> 2 cycles later mantissa 0x800000, exp 100, all flags 0.
REQ-032 Carry: mantissa 0x1800001, exp 100 -> mantissa 0xC00000, exp 101, anOutSticky=1; same with exp 254 -> exp 255, mantissa 0, anOutOverflow=1.
REQ-033 Shift: mantissa 0x0000100, exp 100 -> LZC 15, mantissa 0x800000, exp 85; mantissa 0x0000001, exp 10 -> exp 0, mantissa 0, anOutUnderflow=1, anOutZero=1.
REQ-034 Backpressure: stream 4 beats back-to-back, aOutReady=0 for 3 cycles from the 1st output -> anInReady drops after 2 beats buffered; all 4 beats delivered in order, none lost or duplicated, outputs stable while stalled.
REQ-035 Reset mid-stream: aReset pulsed asynchronously between edges with 2 beats in flight -> anOutValid=0 at once; no stale beat emitted; next input emerges 2 cycles after acceptance.
REQ-036 Zero: mantissa 0, exp 77, aInSticky=1 -> exp 0, mantissa 0, anOutZero=1, anOutSticky=0.
